// File: rtl/id_ctrl_pipe_pkg.sv
// Shared encodings for the ID stage: opcodes, functs, ALU codes, mux selects.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package id_ctrl_pipe_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes, including multiply/divide and HI/LO moves
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // ALU control codes; cast to the configured ALU control width at use
    localparam int ALU_NOP   = 0;
    localparam int ALU_ADD   = 1;
    localparam int ALU_ADDU  = 2;
    localparam int ALU_SUB   = 3;
    localparam int ALU_SUBU  = 4;
    localparam int ALU_AND   = 5;
    localparam int ALU_OR    = 6;
    localparam int ALU_SLT   = 7;
    localparam int ALU_SLL   = 8;
    localparam int ALU_SRL   = 9;
    localparam int ALU_LUI   = 10;
    localparam int ALU_BNE   = 11;
    localparam int ALU_MULT  = 12;
    localparam int ALU_MULTU = 13;
    localparam int ALU_DIV   = 14;
    localparam int ALU_DIVU  = 15;

    // Register destination select
    localparam logic [1:0] REGDST_RT  = 2'd0;
    localparam logic [1:0] REGDST_RD  = 2'd1;
    localparam logic [1:0] REGDST_R31 = 2'd2;

    // ALU operand selects
    localparam int ALUSRC_W = 2;
    localparam logic [ALUSRC_W-1:0] ASRC1_RS    = 2'd0;
    localparam logic [ALUSRC_W-1:0] ASRC1_SHAMT = 2'd1;
    localparam logic [ALUSRC_W-1:0] ASRC2_RT    = 2'd0;
    localparam logic [ALUSRC_W-1:0] ASRC2_IMM   = 2'd1;

    // Immediate extension mode
    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_HIGH = 2'd2;

    // HI/LO read select
    localparam logic [1:0] MDSEL_NONE = 2'd0;
    localparam logic [1:0] MDSEL_HI   = 2'd1;
    localparam logic [1:0] MDSEL_LO   = 2'd2;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // ID/EX control bundle, ALU control kept separate since its width is a parameter
    typedef struct packed {
        logic                jump;
        logic                jr;
        logic                branch;
        logic                memr;
        logic                mem2r;
        logic                memw;
        logic                regw;
        logic [1:0]          regdst;
        logic [ALUSRC_W-1:0] alusrc1;
        logic [ALUSRC_W-1:0] alusrc2;
        logic [1:0]          extop;
        logic                md_start;
        logic [1:0]          md_sel;
    } ctrl_t;

    // ALU operation for the R-type functs that drive the ALU or MD unit
    function automatic int alu_of_funct(input logic [5:0] fn);
        int res;
        res = ALU_NOP;
        case (fn)
            FN_ADD:   res = ALU_ADD;
            FN_ADDU:  res = ALU_ADDU;
            FN_SUB:   res = ALU_SUB;
            FN_SUBU:  res = ALU_SUBU;
            FN_AND:   res = ALU_AND;
            FN_OR:    res = ALU_OR;
            FN_SLT:   res = ALU_SLT;
            FN_SLL:   res = ALU_SLL;
            FN_SRL:   res = ALU_SRL;
            FN_MULT:  res = ALU_MULT;
            FN_MULTU: res = ALU_MULTU;
            FN_DIV:   res = ALU_DIV;
            FN_DIVU:  res = ALU_DIVU;
            default:  res = ALU_NOP;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/id_ctrl_pipe_id_decode.sv
// Combinational opcode/funct decode into the ID/EX control bundle plus operand-use flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides whether the result is used.
module id_decode
    import id_ctrl_pipe_pkg::*;
#(
    parameter int ALUCTRL_W = 5
) (
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    output ctrl_t                ctrl,
    output logic [ALUCTRL_W-1:0] aluctrl,
    output logic                 legal,
    output logic                 reads_rs,
    output logic                 reads_rt
);

    // Decode table; anything not listed is flagged illegal with an empty bundle
    always_comb begin
        ctrl     = '0;
        aluctrl  = '0;
        legal    = 1'b1;
        reads_rs = 1'b0;
        reads_rt = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_SLT, FN_AND, FN_OR: begin
                        ctrl.regw   = 1'b1;
                        ctrl.regdst = REGDST_RD;
                        reads_rs    = 1'b1;
                        reads_rt    = 1'b1;
                        aluctrl     = ALUCTRL_W'(alu_of_funct(funct));
                    end
                    FN_SLL, FN_SRL: begin
                        ctrl.regw    = 1'b1;
                        ctrl.regdst  = REGDST_RD;
                        ctrl.alusrc1 = ASRC1_SHAMT;
                        reads_rt     = 1'b1;
                        aluctrl      = ALUCTRL_W'(alu_of_funct(funct));
                    end
                    FN_JR: begin
                        ctrl.jr  = 1'b1;
                        reads_rs = 1'b1;
                    end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        ctrl.md_start = 1'b1;
                        reads_rs      = 1'b1;
                        reads_rt      = 1'b1;
                        aluctrl       = ALUCTRL_W'(alu_of_funct(funct));
                    end
                    FN_MFHI, FN_MFLO: begin
                        ctrl.regw   = 1'b1;
                        ctrl.regdst = REGDST_RD;
                        ctrl.md_sel = (funct == FN_MFHI) ? MDSEL_HI : MDSEL_LO;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_ORI, OP_SLTI, OP_ADDI: begin
                ctrl.regw    = 1'b1;
                ctrl.alusrc2 = ASRC2_IMM;
                ctrl.extop   = (opcode == OP_ORI) ? EXT_ZERO : EXT_SIGN;
                reads_rs     = 1'b1;
                aluctrl      = (opcode == OP_ORI)  ? ALUCTRL_W'(ALU_OR) :
                               (opcode == OP_SLTI) ? ALUCTRL_W'(ALU_SLT) : ALUCTRL_W'(ALU_ADD);
            end
            OP_LUI: begin
                ctrl.regw    = 1'b1;
                ctrl.alusrc2 = ASRC2_IMM;
                ctrl.extop   = EXT_HIGH;
                aluctrl      = ALUCTRL_W'(ALU_LUI);
            end
            OP_LW: begin
                ctrl.memr    = 1'b1;
                ctrl.mem2r   = 1'b1;
                ctrl.regw    = 1'b1;
                ctrl.alusrc2 = ASRC2_IMM;
                ctrl.extop   = EXT_SIGN;
                reads_rs     = 1'b1;
                aluctrl      = ALUCTRL_W'(ALU_ADD);
            end
            OP_SW: begin
                ctrl.memw    = 1'b1;
                ctrl.alusrc2 = ASRC2_IMM;
                ctrl.extop   = EXT_SIGN;
                reads_rs     = 1'b1;
                reads_rt     = 1'b1;
                aluctrl      = ALUCTRL_W'(ALU_ADD);
            end
            OP_BEQ, OP_BNE: begin
                ctrl.branch = 1'b1;
                ctrl.extop  = EXT_SIGN;
                reads_rs    = 1'b1;
                reads_rt    = 1'b1;
                aluctrl     = (opcode == OP_BEQ) ? ALUCTRL_W'(ALU_SUB) : ALUCTRL_W'(ALU_BNE);
            end
            OP_J: begin
                ctrl.jump = 1'b1;
            end
            OP_JAL: begin
                ctrl.jump   = 1'b1;
                ctrl.regw   = 1'b1;
                ctrl.regdst = REGDST_R31;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/id_ctrl_pipe.sv
// ID stage control: decode, load-use / MD-busy hazard stall, MD sequencing FSM, ID/EX register.
// Latency: 1 cycle from acceptance to bundle on the outputs; stall is same-cycle combinational.
// Backpressure: stall holds PC and IF/ID; flush overrides stall and kills the ID instruction.
module id_ctrl_pipe
    import id_ctrl_pipe_pkg::*;
#(
    parameter int ALUCTRL_W = 5,
    parameter int MD_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [31:0]          instr,
    input  logic                 flush,
    input  logic                 ex_memr,
    input  logic [4:0]           ex_rt,
    output logic                 stall,
    output logic                 illegal,
    output logic                 out_valid,
    output logic                 jump,
    output logic                 jr,
    output logic                 branch,
    output logic                 memr,
    output logic                 mem2r,
    output logic                 memw,
    output logic                 regw,
    output logic [1:0]           regdst,
    output logic [ALUSRC_W-1:0]  alusrc1,
    output logic [ALUSRC_W-1:0]  alusrc2,
    output logic [1:0]           extop,
    output logic [ALUCTRL_W-1:0] aluctrl,
    output logic                 md_start,
    output logic [1:0]           md_sel
);

    localparam int CNT_W = $clog2(MD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_CYCLES - 1);

    ctrl_t                dec_ctrl;
    logic [ALUCTRL_W-1:0] dec_aluctrl;
    logic                 dec_legal;
    logic                 reads_rs;
    logic                 reads_rt;
    logic [4:0]           rs;
    logic [4:0]           rt;
    logic                 live;
    logic                 load_hazard;
    logic                 md_hazard;
    logic                 accept;
    md_state_t            md_state;
    md_state_t            md_state_nxt;
    logic [CNT_W-1:0]     md_cnt;
    logic [CNT_W-1:0]     md_cnt_nxt;
    ctrl_t                ctrl_q;
    logic [ALUCTRL_W-1:0] aluctrl_q;
    logic                 unused_fields;

    assign rs = instr[25:21];
    assign rt = instr[20:16];
    // rd and shamt only matter downstream in EX
    assign unused_fields = ^instr[15:6];

    id_decode #(
        .ALUCTRL_W (ALUCTRL_W)
    ) u_decode (
        .opcode   (instr[31:26]),
        .funct    (instr[5:0]),
        .ctrl     (dec_ctrl),
        .aluctrl  (dec_aluctrl),
        .legal    (dec_legal),
        .reads_rs (reads_rs),
        .reads_rt (reads_rt)
    );

    // An instruction is live in ID when valid and not being killed by a taken branch/jump
    assign live        = in_valid && !flush;
    assign load_hazard = ex_memr && (ex_rt != 5'd0) &&
                         ((reads_rs && (ex_rt == rs)) || (reads_rt && (ex_rt == rt)));
    assign md_hazard   = (md_state == MD_BUSY) &&
                         (dec_ctrl.md_start || (dec_ctrl.md_sel != MDSEL_NONE));
    // Illegal encodings read no registers and are not MD ops, so they never stall
    assign stall       = live && (load_hazard || md_hazard);
    assign accept      = live && !stall && dec_legal;

    // MD FSM state register; reset abandons any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_state <= MD_IDLE;
            md_cnt   <= '0;
        end else begin
            md_state <= md_state_nxt;
            md_cnt   <= md_cnt_nxt;
        end
    end

    // MD FSM next state: load on an accepted MD op, count down, leave BUSY one cycle after zero
    always_comb begin
        md_state_nxt = md_state;
        md_cnt_nxt   = md_cnt;
        case (md_state)
            MD_IDLE: begin
                if (accept && dec_ctrl.md_start) begin
                    md_state_nxt = MD_BUSY;
                    md_cnt_nxt   = CNT_LOAD;
                end
            end
            MD_BUSY: begin
                if (md_cnt == '0) begin
                    md_state_nxt = MD_IDLE;
                end else begin
                    md_cnt_nxt = md_cnt - CNT_W'(1);
                end
            end
            default: begin
                md_state_nxt = MD_IDLE;
                md_cnt_nxt   = '0;
            end
        endcase
    end

    // ID/EX register: decoded bundle on acceptance, all-zero bubble otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            illegal   <= 1'b0;
            ctrl_q    <= '0;
            aluctrl_q <= '0;
        end else begin
            out_valid <= accept;
            illegal   <= live && !dec_legal;
            ctrl_q    <= accept ? dec_ctrl : '0;
            aluctrl_q <= accept ? dec_aluctrl : '0;
        end
    end

    assign jump     = ctrl_q.jump;
    assign jr       = ctrl_q.jr;
    assign branch   = ctrl_q.branch;
    assign memr     = ctrl_q.memr;
    assign mem2r    = ctrl_q.mem2r;
    assign memw     = ctrl_q.memw;
    assign regw     = ctrl_q.regw;
    assign regdst   = ctrl_q.regdst;
    assign alusrc1  = ctrl_q.alusrc1;
    assign alusrc2  = ctrl_q.alusrc2;
    assign extop    = ctrl_q.extop;
    assign aluctrl  = aluctrl_q;
    assign md_start = ctrl_q.md_start;
    assign md_sel   = ctrl_q.md_sel;

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// Bench for id_ctrl_pipe: directed scenarios then random traffic against a mnemonic-level model.
// Latency: expects bundle one cycle after acceptance, stall in the same cycle.
// Backpressure: model tracks load-use and MD-busy stalls and flush priority.
module tb_id_ctrl_pipe;
    import id_ctrl_pipe_pkg::*;

    localparam int MD_CYC = 4;

    // Mnemonic indices used by the stimulus generator and model
    localparam int M_ADD = 0,  M_ADDU = 1,  M_SUB = 2,  M_SUBU = 3,  M_SLL = 4,  M_SRL = 5;
    localparam int M_SLT = 6,  M_AND = 7,   M_OR = 8,   M_JR = 9,    M_MULT = 10, M_MULTU = 11;
    localparam int M_DIV = 12, M_DIVU = 13, M_MFHI = 14, M_MFLO = 15, M_ORI = 16, M_LW = 17;
    localparam int M_SW = 18,  M_BEQ = 19,  M_BNE = 20, M_LUI = 21,  M_SLTI = 22, M_ADDI = 23;
    localparam int M_J = 24,   M_JAL = 25,  M_ILL = 26, M_NONE = 27;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        r;
        logic        rs_rd;
        logic        rt_rd;
        logic        md;
        logic        mf;
        logic [23:0] b;
    } minfo_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instr;
    logic        flush;
    logic        ex_memr;
    logic [4:0]  ex_rt;
    logic        stall;
    logic        illegal;
    logic        out_valid, jump, jr, branch, memr, mem2r, memw, regw;
    logic [1:0]  regdst;
    logic [1:0]  alusrc1, alusrc2;
    logic [1:0]  extop;
    logic [4:0]  aluctrl;
    logic        md_start;
    logic [1:0]  md_sel;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [23:0] exp_vec = '0;
    logic        exp_ill = 1'b0;
    int          md_left = 0;

    always #5 clk = ~clk;

    id_ctrl_pipe #(
        .ALUCTRL_W (5),
        .MD_CYCLES (MD_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .instr     (instr),
        .flush     (flush),
        .ex_memr   (ex_memr),
        .ex_rt     (ex_rt),
        .stall     (stall),
        .illegal   (illegal),
        .out_valid (out_valid),
        .jump      (jump),
        .jr        (jr),
        .branch    (branch),
        .memr      (memr),
        .mem2r     (mem2r),
        .memw      (memw),
        .regw      (regw),
        .regdst    (regdst),
        .alusrc1   (alusrc1),
        .alusrc2   (alusrc2),
        .extop     (extop),
        .aluctrl   (aluctrl),
        .md_start  (md_start),
        .md_sel    (md_sel)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] dut_vec();
        return {out_valid, jump, jr, branch, memr, mem2r, memw, regw, regdst,
                alusrc1, alusrc2, extop, aluctrl, md_start, md_sel};
    endfunction

    // Expected valid bundle for one instruction
    function automatic logic [23:0] bnd(input logic j, input logic jrr, input logic br,
                                        input logic mr, input logic m2r, input logic mw,
                                        input logic rw, input logic [1:0] rd,
                                        input logic [1:0] a1, input logic [1:0] a2,
                                        input logic [1:0] ex, input int alu,
                                        input logic ms, input logic [1:0] sel);
        return {1'b1, j, jrr, br, mr, m2r, mw, rw, rd, a1, a2, ex, 5'(alu), ms, sel};
    endfunction

    function automatic minfo_t rinfo(input logic [5:0] fn, input logic rsr, input logic rtr,
                                     input logic [23:0] b);
        minfo_t m;
        m = '0; m.op = OP_RTYPE; m.fn = fn; m.r = 1'b1; m.rs_rd = rsr; m.rt_rd = rtr; m.b = b;
        return m;
    endfunction

    function automatic minfo_t iinfo(input logic [5:0] op, input logic rsr, input logic rtr,
                                     input logic [23:0] b);
        minfo_t m;
        m = '0; m.op = op; m.rs_rd = rsr; m.rt_rd = rtr; m.b = b;
        return m;
    endfunction

    // Per-mnemonic reference: encoding, registers read, and expected bundle
    function automatic minfo_t info(input int mn);
        minfo_t m;
        m = '0;
        case (mn)
            M_ADD:   m = rinfo(FN_ADD,  1, 1, bnd(0,0,0,0,0,0,1,REGDST_RD,ASRC1_RS,ASRC2_RT,EXT_ZERO,ALU_ADD,0,0));
            M_ADDU:  m = rinfo(FN_ADDU, 1, 1, bnd(0,0,0,0,0,0,1,REGDST_RD,ASRC1_RS,ASRC2_RT,EXT_ZERO,ALU_ADDU,0,0));
            M_SUB:   m = rinfo(FN_SUB,  1, 1, bnd(0,0,0,0,0,0,1,REGDST_RD,ASRC1_RS,ASRC2_RT,EXT_ZERO,ALU_SUB,0,0));
            M_SUBU:  m = rinfo(FN_SUBU, 1, 1, bnd(0,0,0,0,0,0,1,REGDST_RD,ASRC1_RS,ASRC2_RT,EXT_ZERO,ALU_SUBU,0,0));
            M_SLT:   m = rinfo(FN_SLT,  1, 1, bnd(0,0,0,0,0,0,1,REGDST_RD,ASRC1_RS,ASRC2_RT,EXT_ZERO,ALU_SLT,0,0));
            M_AND:   m = rinfo(FN_AND,  1, 1, bnd(0,0,0,0,0,0,1,REGDST_RD,ASRC1_RS,ASRC2_RT,EXT_ZERO,ALU_AND,0,0));
            M_OR:    m = rinfo(FN_OR,   1, 1, bnd(0,0,0,0,0,0,1,REGDST_RD,ASRC1_RS,ASRC2_RT,EXT_ZERO,ALU_OR,0,0));
            M_SLL:   m = rinfo(FN_SLL,  0, 1, bnd(0,0,0,0,0,0,1,REGDST_RD,ASRC1_SHAMT,ASRC2_RT,EXT_ZERO,ALU_SLL,0,0));
            M_SRL:   m = rinfo(FN_SRL,  0, 1, bnd(0,0,0,0,0,0,1,REGDST_RD,ASRC1_SHAMT,ASRC2_RT,EXT_ZERO,ALU_SRL,0,0));
            M_JR:    m = rinfo(FN_JR,   1, 0, bnd(0,1,0,0,0,0,0,REGDST_RT,ASRC1_RS,ASRC2_RT,EXT_ZERO,ALU_NOP,0,0));
            M_MULT:  m = rinfo(FN_MULT, 1, 1, bnd(0,0,0,0,0,0,0,REGDST_RT,ASRC1_RS,ASRC2_RT,EXT_ZERO,ALU_MULT,1,0));
            M_MULTU: m = rinfo(FN_MULTU,1, 1, bnd(0,0,0,0,0,0,0,REGDST_RT,ASRC1_RS,ASRC2_RT,EXT_ZERO,ALU_MULTU,1,0));
            M_DIV:   m = rinfo(FN_DIV,  1, 1, bnd(0,0,0,0,0,0,0,REGDST_RT,ASRC1_RS,ASRC2_RT,EXT_ZERO,ALU_DIV,1,0));
            M_DIVU:  m = rinfo(FN_DIVU, 1, 1, bnd(0,0,0,0,0,0,0,REGDST_RT,ASRC1_RS,ASRC2_RT,EXT_ZERO,ALU_DIVU,1,0));
            M_MFHI:  m = rinfo(FN_MFHI, 0, 0, bnd(0,0,0,0,0,0,1,REGDST_RD,ASRC1_RS,ASRC2_RT,EXT_ZERO,ALU_NOP,0,MDSEL_HI));
            M_MFLO:  m = rinfo(FN_MFLO, 0, 0, bnd(0,0,0,0,0,0,1,REGDST_RD,ASRC1_RS,ASRC2_RT,EXT_ZERO,ALU_NOP,0,MDSEL_LO));
            M_ORI:   m = iinfo(OP_ORI,  1, 0, bnd(0,0,0,0,0,0,1,REGDST_RT,ASRC1_RS,ASRC2_IMM,EXT_ZERO,ALU_OR,0,0));
            M_LW:    m = iinfo(OP_LW,   1, 0, bnd(0,0,0,1,1,0,1,REGDST_RT,ASRC1_RS,ASRC2_IMM,EXT_SIGN,ALU_ADD,0,0));
            M_SW:    m = iinfo(OP_SW,   1, 1, bnd(0,0,0,0,0,1,0,REGDST_RT,ASRC1_RS,ASRC2_IMM,EXT_SIGN,ALU_ADD,0,0));
            M_BEQ:   m = iinfo(OP_BEQ,  1, 1, bnd(0,0,1,0,0,0,0,REGDST_RT,ASRC1_RS,ASRC2_RT,EXT_SIGN,ALU_SUB,0,0));
            M_BNE:   m = iinfo(OP_BNE,  1, 1, bnd(0,0,1,0,0,0,0,REGDST_RT,ASRC1_RS,ASRC2_RT,EXT_SIGN,ALU_BNE,0,0));
            M_LUI:   m = iinfo(OP_LUI,  0, 0, bnd(0,0,0,0,0,0,1,REGDST_RT,ASRC1_RS,ASRC2_IMM,EXT_HIGH,ALU_LUI,0,0));
            M_SLTI:  m = iinfo(OP_SLTI, 1, 0, bnd(0,0,0,0,0,0,1,REGDST_RT,ASRC1_RS,ASRC2_IMM,EXT_SIGN,ALU_SLT,0,0));
            M_ADDI:  m = iinfo(OP_ADDI, 1, 0, bnd(0,0,0,0,0,0,1,REGDST_RT,ASRC1_RS,ASRC2_IMM,EXT_SIGN,ALU_ADD,0,0));
            M_J:     m = iinfo(OP_J,    0, 0, bnd(1,0,0,0,0,0,0,REGDST_RT,ASRC1_RS,ASRC2_RT,EXT_ZERO,ALU_NOP,0,0));
            M_JAL:   m = iinfo(OP_JAL,  0, 0, bnd(1,0,0,0,0,0,1,REGDST_R31,ASRC1_RS,ASRC2_RT,EXT_ZERO,ALU_NOP,0,0));
            default: m = '0;
        endcase
        m.md = (mn >= M_MULT) && (mn <= M_DIVU);
        m.mf = (mn == M_MFHI) || (mn == M_MFLO);
        return m;
    endfunction

    // Build an instruction word for a mnemonic with the given register fields
    function automatic logic [31:0] enc(input int mn, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] low);
        minfo_t m;
        logic [31:0] w;
        m = info(mn);
        if (m.r) w = {OP_RTYPE, rs, rt, low[15:6], m.fn};
        else     w = {m.op, rs, rt, low};
        return w;
    endfunction

    function automatic logic [31:0] enc_illegal(input int kind, input logic [31:0] rnd);
        logic [31:0] w;
        case (kind)
            0:       w = {6'h3F, rnd[25:0]};
            1:       w = {6'h09, rnd[25:0]};
            2:       w = {6'h20, rnd[25:0]};
            3:       w = {6'h00, rnd[25:6], 6'h3F};
            default: w = {6'h00, rnd[25:6], 6'h2B};
        endcase
        return w;
    endfunction

    // One clock: check last cycle's registered result, drive new inputs, check stall, update model
    task automatic cyc(input logic v, input int mn, input logic [31:0] ins,
                       input logic fl, input logic em, input logic [4:0] ert);
        minfo_t m;
        logic   lu, mdh, est, acc;
        @(posedge clk);
        #1;
        chk("bundle", 32'(dut_vec()), 32'(exp_vec));
        chk("illegal", 32'(illegal), 32'(exp_ill));
        in_valid = v;
        instr    = ins;
        flush    = fl;
        ex_memr  = em;
        ex_rt    = ert;
        #1;
        m   = info(mn);
        lu  = em && (ert != 5'd0) &&
              ((m.rs_rd && (ert == ins[25:21])) || (m.rt_rd && (ert == ins[20:16])));
        mdh = (md_left > 0) && (m.md || m.mf);
        est = v && !fl && (lu || mdh);
        chk("stall", 32'(stall), 32'(est));
        acc     = v && !fl && !est && (mn != M_ILL);
        exp_vec = acc ? m.b : '0;
        exp_ill = v && !fl && (mn == M_ILL);
        if (md_left > 0) md_left--;
        if (acc && m.md) md_left = MD_CYC;
    endtask

    task automatic idle();
        cyc(1'b0, M_NONE, 32'h0, 1'b0, 1'b0, 5'd0);
    endtask

    initial begin
        int n_st;
        int n_ms;
        logic [31:0] add_ins, mult_ins, mflo_ins;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        instr    = '0;
        flush    = 1'b0;
        ex_memr  = 1'b0;
        ex_rt    = '0;
        add_ins  = enc(M_ADD, 5'd3, 5'd2, 16'h2000);
        mult_ins = enc(M_MULT, 5'd1, 5'd2, 16'h0000);
        mflo_ins = enc(M_MFLO, 5'd0, 5'd0, 16'h2800);

        // Reset state
        #2;
        chk("rst_bundle", 32'(dut_vec()), 32'h0);
        chk("rst_illegal", 32'(illegal), 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // addi $1,$0,5
        cyc(1'b1, M_ADDI, 32'h20010005, 1'b0, 1'b0, 5'd0);
        idle();
        chk("addi_regw", 32'(regw), 32'h1);
        chk("addi_alusrc2", 32'(alusrc2), 32'(ASRC2_IMM));
        chk("addi_aluctrl", 32'(aluctrl), 32'(ALU_ADD));

        // Load-use on rs, then hazard clears
        cyc(1'b1, M_ADD, add_ins, 1'b0, 1'b1, 5'd3);
        chk("lu_stall", 32'(stall), 32'h1);
        cyc(1'b1, M_ADD, add_ins, 1'b0, 1'b0, 5'd3);
        idle();
        chk("lu_add_issued", 32'(out_valid), 32'h1);

        // mult followed immediately by mflo
        cyc(1'b1, M_MULT, mult_ins, 1'b0, 1'b0, 5'd0);
        n_st = 0;
        n_ms = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, M_MFLO, mflo_ins, 1'b0, 1'b0, 5'd0);
            if (md_start) n_ms++;
            if (!stall) break;
            n_st++;
        end
        idle();
        if (md_start) n_ms++;
        chk("md_stall_cycles", 32'(n_st), 32'(MD_CYC));
        chk("md_start_count", 32'(n_ms), 32'h1);
        chk("mflo_md_sel", 32'(md_sel), 32'(MDSEL_LO));

        // Flush beats a load-use hazard and suppresses an MD start
        cyc(1'b1, M_ADD, add_ins, 1'b1, 1'b1, 5'd3);
        chk("flush_stall", 32'(stall), 32'h0);
        cyc(1'b1, M_MULT, mult_ins, 1'b1, 1'b0, 5'd0);
        cyc(1'b1, M_MFLO, mflo_ins, 1'b0, 1'b0, 5'd0);
        cyc(1'b1, M_ILL, 32'hFC000000, 1'b0, 1'b0, 5'd0);
        idle();
        chk("ill_pulse", 32'(illegal), 32'h1);
        chk("ill_bubble", 32'(out_valid), 32'h0);
        idle();

        // Asynchronous reset while the MD unit is busy
        cyc(1'b1, M_DIV, mult_ins | 32'h2, 1'b0, 1'b0, 5'd0);
        idle();
        chk("pre_arst_md_start", 32'(md_start), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_bundle", 32'(dut_vec()), 32'h0);
        chk("arst_illegal", 32'(illegal), 32'h0);
        exp_vec = '0;
        exp_ill = 1'b0;
        md_left = 0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        cyc(1'b1, M_MFLO, mflo_ins, 1'b0, 1'b0, 5'd0);
        chk("post_rst_no_stall", 32'(stall), 32'h0);
        idle();

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            int          mn;
            int          r;
            logic        v, fl, em;
            logic [4:0]  ert;
            logic [31:0] ins;
            r  = $urandom_range(0, 99);
            if (r < 8)       mn = M_ILL;
            else if (r < 32) mn = $urandom_range(M_MULT, M_MFLO);
            else             mn = $urandom_range(M_ADD, M_JAL);
            if (mn == M_ILL) ins = enc_illegal($urandom_range(0, 4), $urandom);
            else             ins = enc(mn, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                       16'($urandom));
            v   = ($urandom_range(0, 99) < 85);
            fl  = ($urandom_range(0, 99) < 10);
            em  = ($urandom_range(0, 99) < 40);
            ert = 5'($urandom_range(0, 7));
            cyc(v, mn, ins, fl, em, ert);
        end
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
